// File: rtl/request_arbiter_pkg.sv
// request_arbiter_pkg
//   Shared definitions for the four-way request arbiter: requester count,
//   grant index width and the arbiter state encoding.
package request_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/request_arbiter_pick4.sv
// arb_pick4
//   Combinational rotating priority encoder over four request lines.
//   Priority starts at start_i and descends with wrap
//   (start_i, start_i-1, ...), so start_i = 3 is plain fixed priority 3>2>1>0.
// Ports:
//   req_i   - eligible request vector
//   start_i - index holding the highest priority for this search
//   id_o    - winning index (0 when nothing is requested)
//   found_o - high when any request bit is set
module arb_pick4
  import request_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  output logic [ID_W-1:0]    id_o,
  output logic               found_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    id_o    = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = start_i - ID_W'(k);
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/request_arbiter.sv
// request_arbiter
//   Four-way arbiter with fixed or round-robin priority, a per-grant hold
//   limit (HOLD_MAX cycles) and a one-cycle RELEASE gap between grants.
//   A grant revoked by the hold limit masks that requester from the next
//   arbitration unless it is the only one requesting.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req       - request lines, bit 3 highest fixed priority
//   rr_en     - round-robin enable, sampled while IDLE
//   gnt       - registered one-hot grant
//   gnt_id    - registered binary index of the grant (0 when none)
//   gnt_valid - registered, high while a grant is held
//   timeout   - one-cycle pulse when the hold limit revokes a grant
module request_arbiter
  import request_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX   = 16,
  parameter bit          RR_DEFAULT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int              CNT_W     = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic               gnt_valid_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               mask_valid_q;
  logic [ID_W-1:0]    mask_id_q;
  logic [ID_W-1:0]    last_id_q;
  logic               mode_q;

  logic [NUM_REQ-1:0] mask_vec;
  logic [NUM_REQ-1:0] elig_masked;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] elig_rev;
  logic [NUM_REQ-1:0] pick_req;
  logic [ID_W-1:0]    pick_start;
  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_onehot;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bits
    assign mask_vec[gi]   = mask_valid_q && (mask_id_q == ID_W'(gi));
    assign elig_rev[gi]   = elig[NUM_REQ-1-gi];
    assign win_onehot[gi] = (win_id == ID_W'(gi));
  end

  // A masked requester only loses if someone else is asking.
  assign elig_masked = req & ~mask_vec;
  assign elig        = (|elig_masked) ? elig_masked : req;

  // The picker searches downwards. Round-robin must ascend from last_id+1,
  // so the vector is bit-reversed: index i maps to 3-i, the start becomes
  // 3-(last_id+1) = 2-last_id (mod 4), and the result maps back via ~id.
  assign pick_req   = mode_q ? elig_rev : elig;
  assign pick_start = mode_q ? (ID_W'(NUM_REQ - 2) - last_id_q) : ID_W'(NUM_REQ - 1);
  assign win_id     = mode_q ? ~pick_id : pick_id;

  arb_pick4 u_pick (
    .req_i   (pick_req),
    .start_i (pick_start),
    .id_o    (pick_id),
    .found_o (pick_found)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      gnt_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
      mask_valid_q <= 1'b0;
      mask_id_q    <= '0;
      last_id_q    <= ID_W'(NUM_REQ - 1);
      mode_q       <= RR_DEFAULT;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Arbitration uses the mode latched on the previous IDLE edge.
          mode_q <= rr_en;
          if (pick_found) begin
            state_q      <= GRANT;
            gnt_q        <= win_onehot;
            gnt_id_q     <= win_id;
            gnt_valid_q  <= 1'b1;
            cnt_q        <= '0;
            mask_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[gnt_id_q]) begin
            // A drop takes precedence over the hold limit.
            state_q     <= RELEASE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            last_id_q   <= gnt_id_q;
          end else if (cnt_q == HOLD_LAST) begin
            state_q      <= RELEASE;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            gnt_valid_q  <= 1'b0;
            last_id_q    <= gnt_id_q;
            timeout_q    <= 1'b1;
            mask_valid_q <= 1'b1;
            mask_id_q    <= gnt_id_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
